// File: rtl/rvseed_pkg.sv
// Shared constants, decode encodings and the immediate generator for the rvseed RV32I core.
package rvseed_pkg;

    localparam int DEF_CPU_WIDTH  = 32;
    localparam int DEF_IMEM_DEPTH = 1024;
    localparam int DEF_DMEM_DEPTH = 1024;
    localparam int SIM_PERIOD     = 10;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_LB   = 3'b000;
    localparam logic [2:0] F3_LH   = 3'b001;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_LBU  = 3'b100;
    localparam logic [2:0] F3_LHU  = 3'b101;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
    } alu_op_e;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_e;

    typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4, WB_IMM} wb_sel_e;

    typedef struct packed {
        alu_op_e  alu_op;
        imm_sel_e imm_sel;
        wb_sel_e  wb_sel;
        logic     a_pc;
        logic     b_imm;
        logic     reg_we;
        logic     mem_we;
        logic     branch;
        logic     jal;
        logic     jalr;
    } ctrl_t;

    function automatic logic [31:0] imm_gen(input logic [31:0] inst, input imm_sel_e sel);
        case (sel)
            IMM_S:   return {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   return {inst[31:12], 12'b0};
            IMM_J:   return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: return {{20{inst[31]}}, inst[31:20]};
        endcase
    endfunction

endpackage

// File: rtl/data_mem.sv
// Byte-lane data memory: store lane steering on write, load lane select and extension on read.
module data_mem
    import rvseed_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] word,
    input  logic [1:0]    lane,
    input  logic [2:0]    funct3,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] data_mem_f [0:DEPTH-1];
    logic [31:0] cur, wlanes;
    logic [3:0]  be;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    assign cur = data_mem_f[word];

    // Replicate the store data across lanes so only the byte enables depend on the address.
    always_comb begin
        be     = 4'b0000;
        wlanes = wdata;
        case (funct3[1:0])
            2'b00: begin
                be[lane] = 1'b1;
                wlanes   = {4{wdata[7:0]}};
            end
            2'b01: begin
                be     = lane[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{wdata[15:0]}};
            end
            default: be = 4'b1111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) data_mem_f[word][8*i +: 8] <= wlanes[8*i +: 8];
        end
    end

    assign rbyte = cur[8*lane +: 8];
    assign rhalf = lane[1] ? cur[31:16] : cur[15:0];

    always_comb begin
        rdata = cur;
        case (funct3)
            F3_LB:   rdata = {{24{rbyte[7]}}, rbyte};
            F3_LH:   rdata = {{16{rhalf[15]}}, rhalf};
            F3_LBU:  rdata = {24'b0, rbyte};
            F3_LHU:  rdata = {16'b0, rhalf};
            default: rdata = cur;
        endcase
    end

endmodule

// File: rtl/inst_mem.sv
// Instruction ROM with combinational read; normally filled by backdoor, the load port is tied off at the top.
module inst_mem #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    input  logic [AW-1:0] word,
    output logic [31:0]   inst
);

    logic [31:0] inst_mem_f [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (load_en) inst_mem_f[load_addr] <= load_data;
    end

    assign inst = inst_mem_f[word];

endmodule

// File: rtl/reg_file.sv
// 32-entry register file, two combinational read ports, one write port; x0 is hardwired to zero.
module reg_file #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         we,
    input  logic [4:0]   rd,
    input  logic [W-1:0] wdata,
    input  logic [4:0]   rs1,
    input  logic [4:0]   rs2,
    output logic [W-1:0] rdata1,
    output logic [W-1:0] rdata2
);

    logic [W-1:0] reg_f [0:31];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) reg_f[i] <= '0;
        end else if (we && rd != 5'd0) begin
            reg_f[rd] <= wdata;
        end
    end

    assign rdata1 = (rs1 == 5'd0) ? '0 : reg_f[rs1];
    assign rdata2 = (rs2 == 5'd0) ? '0 : reg_f[rs2];

endmodule

// File: rtl/rvseed_alu.sv
// Integer ALU; shifts use the low five bits of operand b.
module rvseed_alu
    import rvseed_pkg::*;
#(
    parameter int W = 32
) (
    input  alu_op_e        op,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [W-1:0]   y
);

    logic [4:0] shamt;
    assign shamt = b[4:0];

    always_comb begin
        y = '0;
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_XOR:  y = a ^ b;
            ALU_OR:   y = a | b;
            ALU_AND:  y = a & b;
            ALU_SLL:  y = a << shamt;
            ALU_SRL:  y = a >> shamt;
            ALU_SRA:  y = $signed(a) >>> shamt;
            ALU_SLT:  y = {{(W-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: y = {{(W-1){1'b0}}, a < b};
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/rvseed_ctrl.sv
// Main decoder: opcode/funct fields to ALU op, immediate format, write-back source and control flow.
module rvseed_ctrl
    import rvseed_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output ctrl_t      ctrl
);

    alu_op_e arith_op;

    always_comb begin
        arith_op = ALU_ADD;
        case (funct3)
            F3_SLL:  arith_op = ALU_SLL;
            F3_SLT:  arith_op = ALU_SLT;
            F3_SLTU: arith_op = ALU_SLTU;
            F3_XOR:  arith_op = ALU_XOR;
            F3_SR:   arith_op = funct7_5 ? ALU_SRA : ALU_SRL;
            F3_OR:   arith_op = ALU_OR;
            F3_AND:  arith_op = ALU_AND;
            default: arith_op = ALU_ADD;
        endcase
    end

    // Anything not decoded below keeps the all-zero control word, i.e. a NOP.
    always_comb begin
        ctrl = '0;
        case (opcode)
            OPC_OP: begin
                ctrl.alu_op = (funct3 == F3_ADD && funct7_5) ? ALU_SUB : arith_op;
                ctrl.reg_we = 1'b1;
            end
            OPC_OP_IMM: begin
                ctrl.alu_op = arith_op;
                ctrl.b_imm  = 1'b1;
                ctrl.reg_we = 1'b1;
            end
            OPC_LOAD: begin
                ctrl.b_imm  = 1'b1;
                ctrl.wb_sel = WB_MEM;
                ctrl.reg_we = 1'b1;
            end
            OPC_STORE: begin
                ctrl.imm_sel = IMM_S;
                ctrl.b_imm   = 1'b1;
                ctrl.mem_we  = 1'b1;
            end
            OPC_BRANCH: begin
                ctrl.imm_sel = IMM_B;
                ctrl.branch  = 1'b1;
            end
            OPC_JAL: begin
                ctrl.imm_sel = IMM_J;
                ctrl.wb_sel  = WB_PC4;
                ctrl.reg_we  = 1'b1;
                ctrl.jal     = 1'b1;
            end
            OPC_JALR: begin
                ctrl.b_imm  = 1'b1;
                ctrl.wb_sel = WB_PC4;
                ctrl.reg_we = 1'b1;
                ctrl.jalr   = 1'b1;
            end
            OPC_LUI: begin
                ctrl.imm_sel = IMM_U;
                ctrl.wb_sel  = WB_IMM;
                ctrl.reg_we  = 1'b1;
            end
            OPC_AUIPC: begin
                ctrl.imm_sel = IMM_U;
                ctrl.a_pc    = 1'b1;
                ctrl.b_imm   = 1'b1;
                ctrl.reg_we  = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/rvseed.sv
// Single-cycle RV32I core: PC register, next-PC mux and the wiring of memories, decoder and ALU.
module rvseed
    import rvseed_pkg::*;
#(
    parameter int CPU_WIDTH  = DEF_CPU_WIDTH,
    parameter int IMEM_DEPTH = DEF_IMEM_DEPTH,
    parameter int DMEM_DEPTH = DEF_DMEM_DEPTH
) (
    input  logic clk,
    input  logic rst_n
);

    localparam int IAW = $clog2(IMEM_DEPTH);
    localparam int DAW = $clog2(DMEM_DEPTH);

    logic [CPU_WIDTH-1:0] pc, pc_next, pc_plus4, br_target;
    logic [CPU_WIDTH-1:0] rs1_val, rs2_val, imm, alu_a, alu_b, alu_y, load_val, wb_val;
    logic [31:0]          inst;
    logic [2:0]           funct3;
    logic                 take_br;
    ctrl_t                ctrl;

    assign funct3 = inst[14:12];

    inst_mem #(.DEPTH(IMEM_DEPTH)) U_INST_MEM (
        .clk       (clk),
        .load_en   (1'b0),
        .load_addr ('0),
        .load_data ('0),
        .word      (pc[IAW+1:2]),
        .inst      (inst)
    );

    rvseed_ctrl U_CTRL (
        .opcode   (inst[6:0]),
        .funct3   (funct3),
        .funct7_5 (inst[30]),
        .ctrl     (ctrl)
    );

    assign imm = imm_gen(inst, ctrl.imm_sel);

    reg_file #(.W(CPU_WIDTH)) U_REG_FILE_0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (ctrl.reg_we),
        .rd     (inst[11:7]),
        .wdata  (wb_val),
        .rs1    (inst[19:15]),
        .rs2    (inst[24:20]),
        .rdata1 (rs1_val),
        .rdata2 (rs2_val)
    );

    assign alu_a = ctrl.a_pc  ? pc  : rs1_val;
    assign alu_b = ctrl.b_imm ? imm : rs2_val;

    rvseed_alu #(.W(CPU_WIDTH)) U_ALU (
        .op (ctrl.alu_op),
        .a  (alu_a),
        .b  (alu_b),
        .y  (alu_y)
    );

    // Stores are gated by reset: the instruction at PC 0 is decoded while reset is held.
    data_mem #(.DEPTH(DMEM_DEPTH)) U_DATA_MEM_0 (
        .clk    (clk),
        .we     (ctrl.mem_we & rst_n),
        .word   (alu_y[DAW+1:2]),
        .lane   (alu_y[1:0]),
        .funct3 (funct3),
        .wdata  (rs2_val),
        .rdata  (load_val)
    );

    always_comb begin
        case (ctrl.wb_sel)
            WB_MEM:  wb_val = load_val;
            WB_PC4:  wb_val = pc_plus4;
            WB_IMM:  wb_val = imm;
            default: wb_val = alu_y;
        endcase
    end

    always_comb begin
        case (funct3)
            F3_BEQ:  take_br = (rs1_val == rs2_val);
            F3_BNE:  take_br = (rs1_val != rs2_val);
            F3_BLT:  take_br = ($signed(rs1_val) <  $signed(rs2_val));
            F3_BGE:  take_br = ($signed(rs1_val) >= $signed(rs2_val));
            F3_BLTU: take_br = (rs1_val <  rs2_val);
            F3_BGEU: take_br = (rs1_val >= rs2_val);
            default: take_br = 1'b0;
        endcase
    end

    assign pc_plus4  = pc + CPU_WIDTH'(4);
    assign br_target = pc + imm;

    always_comb begin
        if (ctrl.jalr)
            pc_next = {alu_y[CPU_WIDTH-1:1], 1'b0};
        else if (ctrl.jal || (ctrl.branch && take_br))
            pc_next = br_target;
        else
            pc_next = pc_plus4;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= '0;
        else        pc <= pc_next;
    end

endmodule

// File: tb/tb_rvseed.sv
// Directed-program bench for rvseed: backdoor-loaded programs with hand-computed register/memory results.
module tb_rvseed;
    import rvseed_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    rvseed dut (.clk(clk), .rst_n(rst_n));

    always #(SIM_PERIOD/2) clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reset the core and fill instruction memory with ADDI x0,x0,0.
    task automatic begin_prog();
        rst_n = 1'b0;
        for (int i = 0; i < DEF_IMEM_DEPTH; i++)
            dut.U_INST_MEM.inst_mem_f[i] <= 32'h0000_0013;
    endtask

    task automatic put(input int addr, input logic [31:0] w);
        dut.U_INST_MEM.inst_mem_f[addr >> 2] <= w;
    endtask

    task automatic start();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] xr(input int i);
        return dut.U_REG_FILE_0.reg_f[i];
    endfunction

    initial begin
        logic [31:0] acc;
        #1;
        // ALU and x0 program; reset held across two edges
        begin_prog();
        put('h00, 32'h0050_0093);   // addi x1,x0,5
        put('h04, 32'h0010_8133);   // add  x2,x1,x1
        put('h08, 32'h4010_01B3);   // sub  x3,x0,x1
        put('h0C, 32'h0070_0013);   // addi x0,x0,7
        put('h10, 32'hFFFF_FFFF);   // unknown opcode
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_pc", dut.pc, 32'h0);
        acc = '0;
        for (int i = 0; i < 32; i++) acc |= xr(i);
        check("rst_regs", acc, 32'h0);
        rst_n = 1'b1;
        run(2);
        check("addi_x1", xr(1), 32'd5);
        check("add_dep_x2", xr(2), 32'd10);
        run(3);
        check("sub_x3", xr(3), 32'hFFFF_FFFB);
        check("x0_zero", xr(0), 32'h0);
        check("nop_x31", xr(31), 32'h0);
        check("nop_pc", dut.pc, 32'h14);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_pc", dut.pc, 32'h0);
        check("midrst_x1", xr(1), 32'h0);

        // Immediate ALU forms, shifts and compares
        @(negedge clk);
        begin_prog();
        put('h00, 32'hFF00_0093);   // addi  x1,x0,-16
        put('h04, 32'h4020_D113);   // srai  x2,x1,2
        put('h08, 32'h01C0_D193);   // srli  x3,x1,28
        put('h0C, 32'hFFF0_B213);   // sltiu x4,x1,-1
        put('h10, 32'h0000_A293);   // slti  x5,x1,0
        put('h14, 32'h0FF0_C313);   // xori  x6,x1,0xff
        put('h18, 32'h0031_93B3);   // sll   x7,x3,x3
        put('h1C, 32'h0011_B433);   // sltu  x8,x3,x1
        start();
        run(8);
        check("srai", xr(2), 32'hFFFF_FFFC);
        check("srli", xr(3), 32'h0000_000F);
        check("sltiu", xr(4), 32'h1);
        check("slti", xr(5), 32'h1);
        check("xori", xr(6), 32'hFFFF_FF0F);
        check("sll", xr(7), 32'h0007_8000);
        check("sltu", xr(8), 32'h1);

        // Memory byte lanes, store-then-load in consecutive cycles
        begin_prog();
        put('h00, 32'h8000_02B7);   // lui  x5,0x80000
        put('h04, 32'h0050_2023);   // sw   x5,0(x0)
        put('h08, 32'h0030_0303);   // lb   x6,3(x0)
        put('h0C, 32'h0030_4383);   // lbu  x7,3(x0)
        put('h10, 32'h0000_01A3);   // sb   x0,3(x0)
        put('h14, 32'h0000_2403);   // lw   x8,0(x0)
        put('h18, 32'hFFF0_0493);   // addi x9,x0,-1
        put('h1C, 32'h0000_2223);   // sw   x0,4(x0)
        put('h20, 32'h0090_1323);   // sh   x9,6(x0)
        put('h24, 32'h0060_1503);   // lh   x10,6(x0)
        put('h28, 32'h0060_5583);   // lhu  x11,6(x0)
        start();
        run(11);
        check("lui_x5", xr(5), 32'h8000_0000);
        check("lb_x6", xr(6), 32'hFFFF_FF80);
        check("lbu_x7", xr(7), 32'h0000_0080);
        check("lw_x8", xr(8), 32'h0);
        check("dmem0", dut.U_DATA_MEM_0.data_mem_f[0], 32'h0);
        check("sh_dmem1", dut.U_DATA_MEM_0.data_mem_f[1], 32'hFFFF_0000);
        check("lh_x10", xr(10), 32'hFFFF_FFFF);
        check("lhu_x11", xr(11), 32'h0000_FFFF);

        // Branches with x1=-1, x2=1
        begin_prog();
        put('h00, 32'hFFF0_0093);   // addi x1,x0,-1
        put('h04, 32'h0010_0113);   // addi x2,x0,1
        put('h08, 32'h0020_C463);   // blt  x1,x2,+8
        put('h0C, 32'h0010_0513);   // addi x10,x0,1
        put('h10, 32'h0020_E463);   // bltu x1,x2,+8
        put('h14, 32'h0010_0593);   // addi x11,x0,1
        put('h18, 32'h0020_F463);   // bgeu x1,x2,+8
        put('h1C, 32'h0010_0613);   // addi x12,x0,1
        put('h20, 32'h0010_8463);   // beq  x1,x1,+8
        put('h24, 32'h0010_0693);   // addi x13,x0,1
        put('h28, 32'h0010_9463);   // bne  x1,x1,+8
        put('h2C, 32'h0010_0713);   // addi x14,x0,1
        start();
        run(3);
        check("blt_taken_pc", dut.pc, 32'h10);
        run(1);
        check("bltu_not_pc", dut.pc, 32'h14);
        run(2);
        check("bgeu_taken_pc", dut.pc, 32'h20);
        run(1);
        check("beq_taken_pc", dut.pc, 32'h28);
        run(2);
        check("bne_not_pc", dut.pc, 32'h30);
        check("skip_x10", xr(10), 32'h0);
        check("exec_x11", xr(11), 32'h1);
        check("skip_x12", xr(12), 32'h0);
        check("skip_x13", xr(13), 32'h0);
        check("exec_x14", xr(14), 32'h1);

        // Jumps, AUIPC, JALR with rd==rs1
        begin_prog();
        put('h10, 32'h0080_00EF);   // jal   x1,+8
        put('h14, 32'h00C0_006F);   // jal   x0,+12
        put('h18, 32'h0010_8067);   // jalr  x0,x1,1
        put('h20, 32'h0000_1217);   // auipc x4,1
        put('h24, 32'h0400_80E7);   // jalr  x1,x1,0x40
        put('h54, 32'hABCD_E3B7);   // lui   x7,0xabcde
        start();
        run(5);
        check("jal_x1", xr(1), 32'h14);
        check("jal_pc", dut.pc, 32'h18);
        run(1);
        check("jalr_pc", dut.pc, 32'h14);
        run(1);
        check("jal2_pc", dut.pc, 32'h20);
        run(1);
        check("auipc_x4", xr(4), 32'h0000_1020);
        run(1);
        check("jalr_rd_pc", dut.pc, 32'h54);
        check("jalr_rd_x1", xr(1), 32'h28);
        run(1);
        check("lui_x7", xr(7), 32'hABCD_E000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
